// File: rtl/alu_wb_stage_pkg.sv
// Shared constants and encodings for the ALU writeback stage.
// Default widths, ALU opcodes, flag bit positions and skid-buffer occupancy states.
package alu_wb_stage_pkg;

  localparam int unsigned WB_DATA_WIDTH     = 16;
  localparam int unsigned WB_FLAGS_WIDTH    = 4;
  localparam int unsigned WB_OPER_WIDTH     = 4;
  localparam int unsigned WB_REG_ADDR_WIDTH = 4;
  localparam int unsigned STAT_WIDTH        = 16;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_CMP = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7
  } alu_oper_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_wb_entry_buf.sv
// Two-entry in-order skid buffer with a generic payload.
// in_ready depends only on registered occupancy, never on out_pop.
module alu_wb_entry_buf
  import alu_wb_stage_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_data,
  input  logic                     out_pop,
  output logic                     head_valid,
  output logic [PAYLOAD_WIDTH-1:0] head_data
);

  occ_state_e               state;
  logic [PAYLOAD_WIDTH-1:0] head_q;
  logic [PAYLOAD_WIDTH-1:0] skid_q;
  logic                     in_ready_q;
  logic                     head_valid_q;
  logic                     accept;
  logic                     retire;

  assign accept     = in_valid & in_ready_q;
  assign retire     = head_valid_q & out_pop;
  assign in_ready   = in_ready_q;
  assign head_valid = head_valid_q;
  assign head_data  = head_q;

  // Occupancy FSM; ready/valid flags are updated alongside the state they decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= OCC_EMPTY;
      head_q       <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
      head_valid_q <= 1'b0;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            head_q       <= in_data;
            head_valid_q <= 1'b1;
            state        <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && retire) begin
            head_q <= in_data;
          end else if (accept) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state      <= OCC_TWO;
          end else if (retire) begin
            head_valid_q <= 1'b0;
            state        <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (retire) begin
            head_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= OCC_ONE;
          end
        end
        default: begin
          in_ready_q   <= 1'b1;
          head_valid_q <= 1'b0;
          state        <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: skid-buffered capture, register-file write port, flags register.
// Optional retire/compare/stall counters are enabled with ALU_WB_STATS_EN.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned FLAGS_WIDTH    = WB_FLAGS_WIDTH,
  parameter int unsigned OPER_WIDTH     = WB_OPER_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
  parameter logic [OPER_WIDTH-1:0] OPER_CMP = OPER_WIDTH'(OP_CMP)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPER_WIDTH-1:0]     in_oper,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [FLAGS_WIDTH-1:0]    in_flags,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  input  logic                      in_write_en,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic                      rf_ready,
  output logic [FLAGS_WIDTH-1:0]    proc_flags,
  output logic                      busy
`ifdef ALU_WB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]     retire_count,
  output logic [STAT_WIDTH-1:0]     cmp_count,
  output logic [STAT_WIDTH-1:0]     stall_count
`endif
);

  localparam int unsigned DEST_LSB   = 1;
  localparam int unsigned FLAGS_LSB  = DEST_LSB + REG_ADDR_WIDTH;
  localparam int unsigned RESULT_LSB = FLAGS_LSB + FLAGS_WIDTH;
  localparam int unsigned BASE_WIDTH = RESULT_LSB + DATA_WIDTH;
`ifdef ALU_WB_STATS_EN
  localparam int unsigned PAYLOAD_WIDTH = BASE_WIDTH + OPER_WIDTH;
`else
  localparam int unsigned PAYLOAD_WIDTH = BASE_WIDTH;
`endif

  logic                      in_wr;
  logic [BASE_WIDTH-1:0]     in_base;
  logic [PAYLOAD_WIDTH-1:0]  in_payload;
  logic [PAYLOAD_WIDTH-1:0]  head_data;
  logic                      head_valid;
  logic                      head_wr;
  logic [REG_ADDR_WIDTH-1:0] head_dest;
  logic [FLAGS_WIDTH-1:0]    head_flags;
  logic [DATA_WIDTH-1:0]     head_result;
  logic                      pop;
  logic                      retire;
  logic [FLAGS_WIDTH-1:0]    flags_q;

  // Compares never write the register file regardless of in_write_en.
  assign in_wr   = in_write_en & (in_oper != OPER_CMP);
  assign in_base = {in_result, in_flags, in_dest, in_wr};

`ifdef ALU_WB_STATS_EN
  logic [OPER_WIDTH-1:0] head_oper;
  assign in_payload = {in_oper, in_base};
  assign head_oper  = head_data[PAYLOAD_WIDTH-1 -: OPER_WIDTH];
`else
  assign in_payload = in_base;
`endif

  assign head_wr     = head_data[0];
  assign head_dest   = head_data[DEST_LSB +: REG_ADDR_WIDTH];
  assign head_flags  = head_data[FLAGS_LSB +: FLAGS_WIDTH];
  assign head_result = head_data[RESULT_LSB +: DATA_WIDTH];

  // Non-writing entries retire without waiting on the register file.
  assign pop    = rf_ready | ~head_wr;
  assign retire = head_valid & pop;

  alu_wb_entry_buf #(
    .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
  ) u_entry_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_payload),
    .out_pop    (pop),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign rf_we      = head_valid & head_wr;
  assign rf_waddr   = head_dest;
  assign rf_wdata   = head_result;
  assign busy       = head_valid;
  assign proc_flags = flags_q;

  // Architectural flags follow retirement order only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (retire) begin
      flags_q <= head_flags;
    end
  end

`ifdef ALU_WB_STATS_EN
  // Retire and compare counts wrap; stall count saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count <= '0;
      cmp_count    <= '0;
      stall_count  <= '0;
    end else begin
      if (retire) begin
        retire_count <= retire_count + STAT_WIDTH'(1);
      end
      if (retire && (head_oper == OPER_CMP)) begin
        cmp_count <= cmp_count + STAT_WIDTH'(1);
      end
      if (rf_we && !rf_ready && (stall_count != '1)) begin
        stall_count <= stall_count + STAT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
